regfile_scoreboard: RTL

//  Parametrised successor of the team's register file: 2 read / 1 write ports, all on the rising clk edge.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/pending_scoreboard.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with pending scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_REG_COUNT  = 16;
    localparam int unsigned ZERO_ADDR          = 0;

endpackage : regfile_pkg

// File: rtl/pending_scoreboard.sv
// One pending bit per register: set by issue, cleared by writeback, set wins on collision.
module pending_scoreboard #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic [IDX_W-1:0] look_idx_1_i,
    input  logic [IDX_W-1:0] look_idx_2_i,
    output logic             pend_1_c_o,
    output logic             pend_2_c_o
);

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;

    // Clear first so a same-cycle issue to the same register leaves it pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_1_c_o = pend_q[look_idx_1_i];
    assign pend_2_c_o = pend_q[look_idx_2_i];

endmodule : pending_scoreboard

// File: rtl/regfile_scoreboard.sv
// 2-read / 1-write register file with write bypass, optional zero register,
// address range checking and a per-register pending scoreboard driving stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned REG_COUNT  = DEFAULT_REG_COUNT,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] src_addr_1,
    input  logic [ADDR_WIDTH-1:0] src_addr_2,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic                  stall_1,
    output logic                  stall_2,
    output logic                  addr_error
);

    localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A    = ADDR_WIDTH'(ZERO_ADDR);
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic BYPASS_EN = (BYPASS != 0);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    // A legal address maps to real, writable storage.
    function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) && !(ZERO_EN && (a == ZERO_A));
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] data_out_1_q, data_out_2_q;
    logic [DATA_WIDTH-1:0] data_out_1_d, data_out_2_d;
    logic                  addr_error_q, addr_error_d;

    logic [IDX_W-1:0] src_idx_1, src_idx_2, dest_idx, issue_idx;
    logic             legal_1, legal_2;
    logic             wr_hit_1, wr_hit_2;
    logic             wr_ok, issue_ok;
    logic             pend_1_c, pend_2_c;

    assign src_idx_1 = src_addr_1[IDX_W-1:0];
    assign src_idx_2 = src_addr_2[IDX_W-1:0];
    assign dest_idx  = dest_addr[IDX_W-1:0];
    assign issue_idx = issue_addr[IDX_W-1:0];

    assign legal_1  = legal(src_addr_1);
    assign legal_2  = legal(src_addr_2);
    assign wr_ok    = enable && write_enable && legal(dest_addr);
    assign issue_ok = enable && issue_valid && legal(issue_addr);

    // A legal source equal to dest implies a legal dest, so no separate dest check.
    assign wr_hit_1 = BYPASS_EN && write_enable && (dest_addr == src_addr_1) && legal_1;
    assign wr_hit_2 = BYPASS_EN && write_enable && (dest_addr == src_addr_2) && legal_2;

    pending_scoreboard #(
        .N     (REG_COUNT),
        .IDX_W (IDX_W)
    ) u_pending (
        .clk          (clk),
        .reset        (reset),
        .set_en_i     (issue_ok),
        .set_idx_i    (issue_idx),
        .clr_en_i     (wr_ok),
        .clr_idx_i    (dest_idx),
        .look_idx_1_i (src_idx_1),
        .look_idx_2_i (src_idx_2),
        .pend_1_c_o   (pend_1_c),
        .pend_2_c_o   (pend_2_c)
    );

    assign stall_1 = legal_1 && pend_1_c && !wr_hit_1;
    assign stall_2 = legal_2 && pend_2_c && !wr_hit_2;

    always_comb begin
        data_out_1_d = '0;
        data_out_2_d = '0;
        if (legal_1) begin
            data_out_1_d = wr_hit_1 ? write_data : regs_q[src_idx_1];
        end
        if (legal_2) begin
            data_out_2_d = wr_hit_2 ? write_data : regs_q[src_idx_2];
        end
        addr_error_d = !in_range(src_addr_1) || !in_range(src_addr_2)
                     || (write_enable && !in_range(dest_addr))
                     || (issue_valid && !in_range(issue_addr));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[dest_idx] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_1_q <= '0;
            data_out_2_q <= '0;
            addr_error_q <= 1'b0;
        end else if (enable) begin
            data_out_1_q <= data_out_1_d;
            data_out_2_q <= data_out_2_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign data_out_1 = data_out_1_q;
    assign data_out_2 = data_out_2_q;
    assign addr_error = addr_error_q;

endmodule : regfile_scoreboard
